// File: rtl/matrix_lsu_row_assembler.sv
// Matrix LSU row assembler: pops words from the LSU load FIFO head, packs them
// into RLEN-bit rows and writes N_ROWS rows of one matrix register through a
// ready-gated RF write port. Columns and rows beyond the requested shape are
// written as zero so the whole register is rewritten on every load.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | waiting for start_i; shape and destination latched on start
//   FILL  | popping up to eff_cols words into the row buffer
//   WRITE | presenting the packed row to the RF until rf_ready_i
module matrix_lsu_row_assembler #(
  parameter int DATA_WIDTH = 32,
  parameter int RLEN       = 128,
  parameter int N_ROWS     = 4,
  parameter int N_REGS     = 8,
  localparam int WPR = RLEN / DATA_WIDTH,
  localparam int RW  = (N_ROWS > 1) ? $clog2(N_ROWS) : 1,
  localparam int GW  = (N_REGS > 1) ? $clog2(N_REGS) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [GW-1:0]         reg_idx_i,
  input  logic [31:0]           rows_i,
  input  logic [31:0]           cols_i,
  output logic                  busy_o,
  output logic                  done_o,
  input  logic [DATA_WIDTH-1:0] lsu_data_i,
  input  logic                  lsu_data_available_i,
  output logic                  lsu_pop_o,
  output logic                  rf_we_o,
  input  logic                  rf_ready_i,
  output logic [GW-1:0]         rf_reg_o,
  output logic [RW-1:0]         rf_row_o,
  output logic [RLEN-1:0]       rf_wdata_o
);

  // Counter widths must hold the clamp value itself (N_ROWS / WPR), not just indices.
  localparam int CW  = $clog2(WPR + 1);
  localparam int RCW = $clog2(N_ROWS + 1);
  localparam logic [31:0] NROWS32 = N_ROWS;
  localparam logic [31:0] WPR32   = WPR;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FILL  = 2'd1;
  localparam logic [1:0] WRITE = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [GW-1:0]   reg_q, reg_d;
  logic [RCW-1:0]  rows_q, rows_d;
  logic [CW-1:0]   cols_q, cols_d;
  logic [RW-1:0]   row_cnt_q, row_cnt_d;
  logic [CW-1:0]   col_cnt_q, col_cnt_d;
  logic [RLEN-1:0] buf_q, buf_d;
  logic            done_q, done_d;
  logic [CW-1:0]   eff_cols;
  logic            pop;

  // Rows past the requested count take no data and are written as zero.
  assign eff_cols = (RCW'(row_cnt_q) < rows_q) ? cols_q : '0;

  // Next-state, buffer packing and pop decision.
  always_comb begin
    state_d   = state_q;
    reg_d     = reg_q;
    rows_d    = rows_q;
    cols_d    = cols_q;
    row_cnt_d = row_cnt_q;
    col_cnt_d = col_cnt_q;
    buf_d     = buf_q;
    done_d    = 1'b0;
    pop       = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          reg_d     = reg_idx_i;
          rows_d    = (rows_i > NROWS32) ? RCW'(N_ROWS) : RCW'(rows_i);
          cols_d    = (cols_i > WPR32) ? CW'(WPR) : CW'(cols_i);
          row_cnt_d = '0;
          col_cnt_d = '0;
          buf_d     = '0;
          state_d   = FILL;
        end
      end
      FILL: begin
        pop = lsu_data_available_i && (col_cnt_q < eff_cols);
        if (col_cnt_q == eff_cols) begin
          state_d = WRITE;
        end else if (pop) begin
          for (int w = 0; w < WPR; w++) begin
            if (col_cnt_q == CW'(w)) buf_d[w*DATA_WIDTH +: DATA_WIDTH] = lsu_data_i;
          end
          col_cnt_d = col_cnt_q + CW'(1);
          if ((col_cnt_q + CW'(1)) == eff_cols) state_d = WRITE;
        end
      end
      WRITE: begin
        if (rf_ready_i) begin
          buf_d     = '0;
          col_cnt_d = '0;
          if (row_cnt_q == RW'(N_ROWS - 1)) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            row_cnt_d = row_cnt_q + RW'(1);
            state_d   = FILL;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset clears everything including the buffer.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      reg_q     <= '0;
      rows_q    <= '0;
      cols_q    <= '0;
      row_cnt_q <= '0;
      col_cnt_q <= '0;
      buf_q     <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      reg_q     <= reg_d;
      rows_q    <= rows_d;
      cols_q    <= cols_d;
      row_cnt_q <= row_cnt_d;
      col_cnt_q <= col_cnt_d;
      buf_q     <= buf_d;
      done_q    <= done_d;
    end
  end

  assign busy_o     = (state_q != IDLE);
  assign done_o     = done_q;
  assign lsu_pop_o  = pop;
  assign rf_we_o    = (state_q == WRITE);
  assign rf_reg_o   = reg_q;
  assign rf_row_o   = row_cnt_q;
  assign rf_wdata_o = (state_q == WRITE) ? buf_q : '0;

endmodule
